mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
Parametrised memory-port controller between the multi-cycle MIPS controller/datapath and a unified instruction/data memory with variable latency. It replaces the fixed single-cycle readData path and the bare instruction register. It accepts one request per multi-cycle step and runs a valid/ready request plus response handshake to memory. It owns the instruction register and memory data register, stalls the core until the access completes, and flags a sticky bus error on timeout.

Parameters:
AW, 32, address width
DW, 32, data width; multiple of 8, >= 8
TIMEOUT, 255, max cycles spent in REQ or WAIT_RSP before error; >= 1
IR_RESET, 0, reset value of instr

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low; reset==0 at posedge resets
core_req  in  1  access request for current step, level
core_we  in  1  1 = write, 0 = read
core_isfetch  in  1  read destination: 1 = instr, 0 = mdr
core_adr  in  AW  byte address
core_wdata  in  DW  write data
core_be  in  DW/8  byte enables
core_stall  out  1  core must hold its state
instr  out  DW  instruction register
mdr  out  DW  memory data register
bus_err  out  1  sticky timeout flag
m_valid  out  1  request valid
m_ready  in  1  memory accepts request
m_we  out  1  request is write
m_adr  out  AW  request address
m_wdata  out  DW  request write data
m_be  out  DW/8  request byte enables
m_rvalid  in  1  read response valid
m_rdata  in  DW  read response data

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, instr=IR_RESET, mdr=0, bus_err=0, counter=0, latched request fields=0. This forces m_valid=0 and core_stall=0. Reset at any point abandons an in-flight access. A late m_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT_RSP, DONE, ERR.
- IDLE: if core_req=1, latch core_we/isfetch/adr/wdata/be, go to REQ, clear counter.
- REQ:
  - m_valid=1; m_we/m_adr/m_wdata/m_be driven from latched registers and stable until handshake.
  - Handshake = m_valid && m_ready.
  - On handshake: write goes to DONE (posted write, no response); read goes to WAIT_RSP and clears counter.
  - No handshake: counter increments.
- WAIT_RSP:
  - m_valid=0.
  - On m_rvalid: capture the full m_rdata word into instr if isfetch, else into mdr (byte enables do not mask capture); go to DONE.
  - Otherwise counter increments.
  - m_rvalid is honoured only in WAIT_RSP. A same-cycle response to the REQ handshake is not supported and is ignored.
- Timeout: counter reaching TIMEOUT in REQ or WAIT_RSP sends the FSM to ERR; counter saturates there.
- DONE: lasts exactly one cycle; core_stall=0; core_req ignored; go to IDLE. This prevents a still-asserted core_req from re-issuing the same access.
- ERR: bus_err=1, m_valid=0, core_stall=1. Exit only via reset.
- core_stall = (state==IDLE && core_req) || REQ || WAIT_RSP || ERR. This is combinational from state and core_req.
- Minimum latencies:
  - Read: 4 cycles from req sample to DONE (IDLE, REQ, WAIT_RSP, DONE).
  - Write: 3 cycles.
- instr and mdr hold their value except on capture. The unselected register is never written.
- m_* payload outside REQ holds the last latched values; consumers treat it as don't-care.

Decomposition:
- Package mem_port_pkg:
  - state enum typedef mp_state_t {IDLE, REQ, WAIT_RSP, DONE, ERR};
  - helper localparam function for BE width (DW/8);
  - counter width = $clog2(TIMEOUT+1).
- One sub-module, mp_wait_timer: clear/increment/saturate counter with a "expired" output, parametrised by TIMEOUT.
- instr and mdr use the existing enabled-flop pattern with synchronous active-low reset.

Test Plan:
1. reset=0 for 2 cycles, then 1 -> instr=IR_RESET, mdr=0, m_valid=0, core_stall=0, bus_err=0. Check the same with core_req=1 held during reset: no request issued while reset=0.
2. Fetch: core_req=1, isfetch=1, adr=0x0000_0004, m_ready=1 immediately, m_rvalid=1 one cycle after handshake with m_rdata=0x2002_0005 -> m_valid high only in cycle 1, core_stall high cycles 0–2, low cycle 3. instr=0x2002_0005 from cycle 3; mdr unchanged.
3. Write with backpressure: core_we=1, adr=0x54, wdata=0xDEAD_BEEF, be=4'hF, m_ready low 3 cycles -> m_valid/m_adr/m_wdata/m_be stable all 4 cycles, DONE the cycle after handshake, no wait for m_rvalid.
4. Load: isfetch=0, be=4'b0010, memory returns 0x1234_5678 after 2 wait cycles -> mdr=0x1234_5678, instr unchanged. core_req held high through DONE causes no second request until it has been seen in IDLE.
5. Timeout (TIMEOUT=8): m_ready held 0 -> ERR after 8 REQ cycles, then bus_err=1, m_valid=0, core_stall=1 persisting for 20+ cycles, cleared only by reset=0.
6. Reset mid-WAIT_RSP: reset=0 one cycle during WAIT_RSP, then m_rvalid=1 with 0xFFFF_FFFF -> ignored, mdr=0, state IDLE, core_stall=0.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and width helpers for the memory-port controller.
package mem_port_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, DONE, ERR} mp_state_t;

  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mp_wait_timer.sv
// Wait-cycle counter: clear, increment, saturate at TIMEOUT; latency 0 (expired is combinational).
// No backpressure; expired flags that the current wait cycle is the last one allowed.
module mp_wait_timer
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int            CW   = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAXV = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAXV)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is judged before the increment so that exactly TIMEOUT wait cycles are spent.
  assign expired = (cnt >= LAST);

endmodule

// File: rtl/mem_port_ctrl.sv
// Core-to-memory port: owns instr/mdr, read min 4 cycles, write min 3 cycles req-to-DONE.
// Core stalls while an access is in flight; memory backpressure via m_ready holds REQ.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] IR_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic                  core_isfetch,
  input  logic [AW-1:0]         core_adr,
  input  logic [DW-1:0]         core_wdata,
  input  logic [be_w(DW)-1:0]   core_be,
  output logic                  core_stall,
  output logic [DW-1:0]         instr,
  output logic [DW-1:0]         mdr,
  output logic                  bus_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_we,
  output logic [AW-1:0]         m_adr,
  output logic [DW-1:0]         m_wdata,
  output logic [be_w(DW)-1:0]   m_be,
  input  logic                  m_rvalid,
  input  logic [DW-1:0]         m_rdata
);

  mp_state_t             state, state_nxt;
  logic                  lat_en, cap, t_clr, t_inc, t_exp;
  logic                  we_q, isf_q;
  logic [AW-1:0]         adr_q;
  logic [DW-1:0]         wdata_q;
  logic [be_w(DW)-1:0]   be_q;

  mp_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (t_clr),
    .inc     (t_inc),
    .expired (t_exp)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      isf_q   <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (lat_en) begin
      we_q    <= core_we;
      isf_q   <= core_isfetch;
      adr_q   <= core_adr;
      wdata_q <= core_wdata;
      be_q    <= core_be;
    end
  end

  // Whole-word capture; byte enables only qualify writes on the memory side.
  always_ff @(posedge clk) begin
    if (!reset)            instr <= IR_RESET;
    else if (cap && isf_q) instr <= m_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset)             mdr <= '0;
    else if (cap && !isf_q) mdr <= m_rdata;
  end

  always_comb begin
    state_nxt = state;
    lat_en    = 1'b0;
    cap       = 1'b0;
    t_clr     = 1'b0;
    t_inc     = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE: begin
        t_clr = 1'b1;
        if (core_req) begin
          lat_en    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        m_valid = 1'b1;
        if (m_ready) begin
          t_clr     = 1'b1;
          state_nxt = we_q ? DONE : WAIT_RSP;
        end else begin
          t_inc = 1'b1;
          if (t_exp) state_nxt = ERR;
        end
      end
      WAIT_RSP: begin
        if (m_rvalid) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end else begin
          t_inc = 1'b1;
          if (t_exp) state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign core_stall = ((state == IDLE) && core_req) || (state == REQ) ||
                      (state == WAIT_RSP) || (state == ERR);
  assign bus_err    = (state == ERR);
  assign m_we       = we_q;
  assign m_adr      = adr_q;
  assign m_wdata    = wdata_q;
  assign m_be       = be_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: vector table for fetch/load, hand sequences for
// write backpressure, timeout and reset during a pending read.
module tb_mem_port_ctrl;

  localparam int          TO  = 8;
  localparam logic [31:0] IRR = 32'h0000_0013;

  logic        clk, reset;
  logic        core_req, core_we, core_isfetch;
  logic [31:0] core_adr, core_wdata;
  logic [3:0]  core_be;
  logic        core_stall, bus_err;
  logic [31:0] instr, mdr;
  logic        m_valid, m_ready, m_we, m_rvalid;
  logic [31:0] m_adr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int total = 0;
  int bad   = 0;

  mem_port_ctrl #(.AW(32), .DW(32), .TIMEOUT(TO), .IR_RESET(IRR)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_isfetch(core_isfetch),
    .core_adr(core_adr), .core_wdata(core_wdata), .core_be(core_be),
    .core_stall(core_stall), .instr(instr), .mdr(mdr), .bus_err(bus_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_adr(m_adr),
    .m_wdata(m_wdata), .m_be(m_be), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req, we, isf;
    logic [31:0] adr;
    logic [3:0]  be;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_stall, e_mv;
    logic [31:0] e_instr, e_mdr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic req, we, isf, input logic [31:0] adr,
                              input logic [3:0] be, input logic rdy, rv,
                              input logic [31:0] rdata, input logic e_stall, e_mv,
                              input logic [31:0] e_instr, e_mdr);
    vec_t v;
    v.req = req; v.we = we; v.isf = isf; v.adr = adr; v.be = be;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.e_stall = e_stall; v.e_mv = e_mv; v.e_instr = e_instr; v.e_mdr = e_mdr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i1;
    i1 = 32'h2002_0005;
    reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_isfetch = 1'b0;
    core_adr = '0; core_wdata = '0; core_be = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

    // Reset for two cycles, then release.
    tick(); tick();
    chk("rst instr", instr, IRR);
    chk("rst mdr", {31'b0, 1'b0} | mdr, 32'h0);
    chk("rst m_valid", {31'b0, m_valid}, 32'h0);
    chk("rst stall", {31'b0, core_stall}, 32'h0);
    chk("rst bus_err", {31'b0, bus_err}, 32'h0);
    reset = 1'b1;
    tick();
    chk("post-rst stall", {31'b0, core_stall}, 32'h0);
    chk("post-rst m_valid", {31'b0, m_valid}, 32'h0);

    // Request held while in reset must not reach memory.
    reset = 1'b0; core_req = 1'b1; core_isfetch = 1'b1; core_adr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst-req%0d m_valid", k), {31'b0, m_valid}, 32'h0);
    end
    core_req = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst-req instr", instr, IRR);

    // Fetch (with a same-cycle response at handshake that must be ignored), then loads.
    vq.push_back(mk(1,0,1,32'h4,4'hF,1,0,32'h0,         1,0,IRR,0));
    vq.push_back(mk(1,0,1,32'h4,4'hF,1,1,32'hBAD0_BAD0, 1,1,IRR,0));
    vq.push_back(mk(1,0,1,32'h4,4'hF,0,1,i1,            1,0,IRR,0));
    vq.push_back(mk(1,0,1,32'h4,4'hF,0,0,32'h0,         0,0,i1,0));
    vq.push_back(mk(0,0,1,32'h4,4'hF,0,0,32'h0,         0,0,i1,0));
    vq.push_back(mk(1,0,0,32'h100,4'h2,1,0,32'h0,       1,0,i1,0));
    vq.push_back(mk(1,0,0,32'h100,4'h2,1,0,32'h0,       1,1,i1,0));
    vq.push_back(mk(1,0,0,32'h100,4'h2,0,0,32'h0,       1,0,i1,0));
    vq.push_back(mk(1,0,0,32'h100,4'h2,0,0,32'h0,       1,0,i1,0));
    vq.push_back(mk(1,0,0,32'h100,4'h2,0,1,32'h1234_5678,1,0,i1,0));
    vq.push_back(mk(1,0,0,32'h100,4'h2,0,0,32'h0,       0,0,i1,32'h1234_5678));
    vq.push_back(mk(1,0,0,32'h100,4'h2,0,0,32'h0,       1,0,i1,32'h1234_5678));
    vq.push_back(mk(1,0,0,32'h100,4'h2,1,0,32'h0,       1,1,i1,32'h1234_5678));
    vq.push_back(mk(1,0,0,32'h100,4'h2,0,1,32'hCAFE_F00D,1,0,i1,32'h1234_5678));
    vq.push_back(mk(0,0,0,32'h100,4'h2,0,0,32'h0,       0,0,i1,32'hCAFE_F00D));
    vq.push_back(mk(0,0,0,32'h100,4'h2,0,0,32'h0,       0,0,i1,32'hCAFE_F00D));

    for (int i = 0; i < vq.size(); i++) begin
      core_req = vq[i].req; core_we = vq[i].we; core_isfetch = vq[i].isf;
      core_adr = vq[i].adr; core_be = vq[i].be;
      m_ready = vq[i].rdy; m_rvalid = vq[i].rv; m_rdata = vq[i].rdata;
      #1;
      chk($sformatf("vec%0d stall", i), {31'b0, core_stall}, {31'b0, vq[i].e_stall});
      chk($sformatf("vec%0d m_valid", i), {31'b0, m_valid}, {31'b0, vq[i].e_mv});
      chk($sformatf("vec%0d instr", i), instr, vq[i].e_instr);
      chk($sformatf("vec%0d mdr", i), mdr, vq[i].e_mdr);
      chk($sformatf("vec%0d bus_err", i), {31'b0, bus_err}, 32'h0);
      tick();
    end
    m_rvalid = 1'b0; m_ready = 1'b0;

    // Write with three cycles of backpressure; core-side changes must not leak out.
    core_req = 1'b1; core_we = 1'b1; core_isfetch = 1'b0;
    core_adr = 32'h54; core_wdata = 32'hDEAD_BEEF; core_be = 4'hF;
    #1;
    chk("wr idle stall", {31'b0, core_stall}, 32'h1);
    tick();
    for (int k = 0; k < 4; k++) begin
      core_adr = 32'hFFFF_0000 + k; core_wdata = k; core_be = 4'h0;
      m_ready = (k == 3);
      #1;
      chk($sformatf("wr%0d m_valid", k), {31'b0, m_valid}, 32'h1);
      chk($sformatf("wr%0d m_we", k), {31'b0, m_we}, 32'h1);
      chk($sformatf("wr%0d m_adr", k), m_adr, 32'h54);
      chk($sformatf("wr%0d m_wdata", k), m_wdata, 32'hDEAD_BEEF);
      chk($sformatf("wr%0d m_be", k), {28'b0, m_be}, 32'hF);
      chk($sformatf("wr%0d stall", k), {31'b0, core_stall}, 32'h1);
      tick();
    end
    core_req = 1'b0; m_ready = 1'b0;
    #1;
    chk("wr done stall", {31'b0, core_stall}, 32'h0);
    chk("wr done m_valid", {31'b0, m_valid}, 32'h0);
    chk("wr done mdr", mdr, 32'hCAFE_F00D);
    tick();
    chk("wr idle2 m_valid", {31'b0, m_valid}, 32'h0);
    chk("wr idle2 stall", {31'b0, core_stall}, 32'h0);

    // Timeout: memory never accepts.
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h200; m_ready = 1'b0;
    tick();
    for (int k = 0; k < TO; k++) begin
      #1;
      chk($sformatf("to req%0d m_valid", k), {31'b0, m_valid}, 32'h1);
      chk($sformatf("to req%0d bus_err", k), {31'b0, bus_err}, 32'h0);
      tick();
    end
    for (int k = 0; k < 22; k++) begin
      m_ready = k[0]; m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
      #1;
      chk($sformatf("err%0d bus_err", k), {31'b0, bus_err}, 32'h1);
      chk($sformatf("err%0d m_valid", k), {31'b0, m_valid}, 32'h0);
      chk($sformatf("err%0d stall", k), {31'b0, core_stall}, 32'h1);
      tick();
    end
    reset = 1'b0; core_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("err-rst bus_err", {31'b0, bus_err}, 32'h0);
    chk("err-rst stall", {31'b0, core_stall}, 32'h0);
    chk("err-rst instr", instr, IRR);
    chk("err-rst mdr", mdr, 32'h0);
    tick();

    // Reset while waiting for a read response; the late response is dropped.
    core_req = 1'b1; core_isfetch = 1'b0; core_adr = 32'h300; m_ready = 1'b1;
    tick();
    #1;
    chk("rw req m_valid", {31'b0, m_valid}, 32'h1);
    tick();
    core_req = 1'b0; m_ready = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rw late stall", {31'b0, core_stall}, 32'h0);
    chk("rw late m_valid", {31'b0, m_valid}, 32'h0);
    chk("rw late mdr", mdr, 32'h0);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("rw after mdr", mdr, 32'h0);
    chk("rw after instr", instr, IRR);
    chk("rw after stall", {31'b0, core_stall}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
